// File: rtl/alu_resp_unit.sv
// ALU responder: computes {result, zero} per accepted request and returns them in order through a small FIFO.
// Optional build macro ALU_RSP_CHECK_EN adds req_exp, rsp_err and err_cnt for on-chip result checking.
module alu_resp_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
`ifdef ALU_RSP_CHECK_EN
    input  logic [31:0]      req_exp,
    output logic             rsp_err,
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] rsp_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef ALU_RSP_CHECK_EN
    localparam int ENT_W = 65;
`else
    localparam int ENT_W = 33;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] last_q;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head;
    logic [31:0]      alu_res;
    logic             alu_zero;
    logic             push;
    logic             pop;

    // ALU: undefined opcodes fall through to zero
    always_comb begin
        alu_res = '0;
        case (req_op)
            4'b0000: alu_res = req_a & req_b;
            4'b0001: alu_res = req_a | req_b;
            4'b0010: alu_res = req_a + req_b;
            4'b0011: alu_res = req_a ^ req_b;
            4'b0100: alu_res = ~(req_a | req_b);
            4'b1010: alu_res = req_a - req_b;
            4'b1011: alu_res = {31'b0, ($signed(req_a) < $signed(req_b))};
            default: alu_res = '0;
        endcase
    end

    assign alu_zero = (alu_res == 32'h0);

`ifdef ALU_RSP_CHECK_EN
    assign wr_entry = {req_exp, alu_zero, alu_res};
`else
    assign wr_entry = {alu_zero, alu_res};
`endif

    assign req_ready = (state != FULL);
    assign rsp_valid = (state != IDLE);
    assign push      = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: storage is not reset; pointers and state alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Empty FIFO presents the last popped entry rather than a stale slot.
    assign head       = mem[rd_ptr];
    assign rsp_result = (state == IDLE) ? last_q[31:0] : head[31:0];
    assign rsp_zero   = (state == IDLE) ? last_q[32]   : head[32];

`ifdef ALU_RSP_CHECK_EN
    logic [31:0] exp_head;
    assign exp_head = (state == IDLE) ? last_q[64:33] : head[64:33];
    assign rsp_err  = (rsp_result != exp_head) || (rsp_zero != (exp_head == 32'h0));

    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= '0;
        else if (pop && rsp_err)
            err_cnt <= err_cnt + CNT_W'(1);
    end
`endif

    // Status FSM plus pointers, occupancy and the consumed-response counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rsp_cnt <= '0;
            last_q  <= ENT_W'(33'h1_0000_0000);
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rsp_cnt <= rsp_cnt + CNT_W'(1);
                last_q  <= head;
            end
            count <= count_next;
            if (count_next == '0)
                state <= IDLE;
            else if (count_next == FULL_CNT)
                state <= FULL;
            else
                state <= BUSY;
        end
    end

endmodule

// File: tb/tb_alu_resp_unit.sv
// Directed self-checking bench for alu_resp_unit (DEPTH=2, CNT_W=11).
module tb_alu_resp_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [10:0] rsp_cnt;
`ifdef ALU_RSP_CHECK_EN
    logic [31:0] req_exp;
    logic        rsp_err;
    logic [10:0] err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    alu_resp_unit #(.DEPTH(2), .CNT_W(11)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef ALU_RSP_CHECK_EN
        .req_exp    (req_exp),
        .rsp_err    (rsp_err),
        .err_cnt    (err_cnt),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_cnt    (rsp_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
`ifdef ALU_RSP_CHECK_EN
        req_exp   = exp;
`else
        if (exp === 32'hx) req_op = op;
`endif
    endtask

    // Single operation with rsp_ready high: accept, check head, then pop.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
        drive(op, a, b, exp_res);
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_result"}, rsp_result, exp_res);
        check({tag, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    int base_cnt;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_op    = 4'h0;
        req_a     = 32'h0;
        req_b     = 32'h0;
`ifdef ALU_RSP_CHECK_EN
        req_exp   = 32'h0;
`endif
        step();
        step();
        reset = 1'b0;

        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_cnt", 32'(rsp_cnt), 32'd0);
        check("rst_result", rsp_result, 32'h0);
        check("rst_zero", 32'(rsp_zero), 32'd1);

        // ADD 5+3: response one cycle after accept, counted after pop, value held when empty
        drive(4'b0010, 32'h5, 32'h3, 32'h8);
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_result", rsp_result, 32'h8);
        check("add_zero", 32'(rsp_zero), 32'd0);
        check("add_cnt_pre", 32'(rsp_cnt), 32'd0);
        step();
        check("add_cnt_post", 32'(rsp_cnt), 32'd1);
        check("add_empty", 32'(rsp_valid), 32'd0);
        check("add_hold", rsp_result, 32'h8);

        do_op("sub_eq", 4'b1010, 32'h12345678, 32'h12345678, 32'h0, 1'b1);
        do_op("sub_wrap", 4'b1010, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0);
        do_op("slt_neg", 4'b1011, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
        do_op("slt_pos", 4'b1011, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_op("op_f", 4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1);
        do_op("or", 4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0);
        do_op("xor", 4'b0011, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 1'b1);
        do_op("nor", 4'b0100, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
        do_op("add_ovf", 4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1);
        check("cnt_after_ops", 32'(rsp_cnt), 32'd10);

        // Backpressure: two accepts fill the FIFO, third request waits for space
        rsp_ready = 1'b0;
        drive(4'b0010, 32'h1, 32'h1, 32'h2);
        step();
        check("bp_ready1", 32'(req_ready), 32'd1);
        check("bp_head1", rsp_result, 32'h2);
        drive(4'b0010, 32'h2, 32'h2, 32'h4);
        step();
        check("bp_full", 32'(req_ready), 32'd0);
        drive(4'b0010, 32'h3, 32'h3, 32'h6);
        step();
        check("bp_still_full", 32'(req_ready), 32'd0);
        check("bp_head_hold", rsp_result, 32'h2);
        rsp_ready = 1'b1;
        step();
        check("bp_pop1_ready", 32'(req_ready), 32'd1);
        check("bp_resp2", rsp_result, 32'h4);
        step();
        req_valid = 1'b0;
        check("bp_resp3", rsp_result, 32'h6);
        check("bp_resp3_valid", 32'(rsp_valid), 32'd1);
        check("bp_same_cycle_ready", 32'(req_ready), 32'd1);
        step();
        check("bp_drained", 32'(rsp_valid), 32'd0);
        check("bp_cnt", 32'(rsp_cnt), 32'd13);

        // Streaming 12 vectors from reset: one response per cycle, 13 cycles total
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            drive(4'b0010, 32'(i), 32'(3 * i), 32'(4 * i));
            step();
            check($sformatf("stream_%0d", i), rsp_result, 32'(4 * i));
            check($sformatf("stream_rdy_%0d", i), 32'(req_ready), 32'd1);
        end
        req_valid = 1'b0;
        step();
        check("stream_cnt", 32'(rsp_cnt), 32'd12);
        check("stream_empty", 32'(rsp_valid), 32'd0);

        // Reset with FIFO full; a request coinciding with reset is dropped
        rsp_ready = 1'b0;
        drive(4'b0001, 32'h1, 32'h2, 32'h3);
        step();
        step();
        check("pre_rst_full", 32'(req_ready), 32'd0);
        reset = 1'b1;
        drive(4'b0010, 32'h7, 32'h7, 32'hE);
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        check("rst2_valid", 32'(rsp_valid), 32'd0);
        check("rst2_ready", 32'(req_ready), 32'd1);
        check("rst2_cnt", 32'(rsp_cnt), 32'd0);
        check("rst2_result", rsp_result, 32'h0);
        check("rst2_zero", 32'(rsp_zero), 32'd1);
        step();
        check("rst2_dropped", 32'(rsp_valid), 32'd0);
        do_op("and", 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0);
        check("and_cnt", 32'(rsp_cnt), 32'd1);

`ifdef ALU_RSP_CHECK_EN
        do_reset();
        rsp_ready = 1'b1;
        drive(4'b0010, 32'h2, 32'h2, 32'h5);
        step();
        req_valid = 1'b0;
        check("chk_err_bad", 32'(rsp_err), 32'd1);
        step();
        check("chk_errcnt1", 32'(err_cnt), 32'd1);
        drive(4'b0001, 32'h0, 32'h0, 32'h0);
        step();
        req_valid = 1'b0;
        check("chk_err_good", 32'(rsp_err), 32'd0);
        step();
        check("chk_errcnt_hold", 32'(err_cnt), 32'd1);
`endif

        // Counter wrap: 2048 pops from reset return rsp_cnt to 0, one more gives 1
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            drive(4'b0010, 32'(i), 32'h0, 32'(i));
            step();
        end
        req_valid = 1'b0;
        step();
        check("wrap_cnt0", 32'(rsp_cnt), 32'd0);
        base_cnt = 1;
        do_op("wrap_next", 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1);
        check("wrap_cnt1", 32'(rsp_cnt), 32'(base_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
